// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end of the RAM.
package spi_slave_pkg;

    localparam int FRAME_BITS = 10;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/spi_piso_shifter.sv
// Parallel-in serial-out register for RAM read data, MSB first.
module spi_piso_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         bit_o,
    output logic         done_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  sh_q,   sh_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_q,  bit_d;

    // One load per frame: once done, further loads wait for a clear.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        bit_d  = bit_q;
        if (clear_i) begin
            sh_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b0;
            bit_d  = 1'b0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                bit_d  = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                bit_d = sh_q[W-1];
                sh_d  = {sh_q[W-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
            end
        end else if (load_i && !done_q) begin
            bit_d  = data_i[W-1];
            sh_d   = {data_i[W-2:0], 1'b0};
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bit_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bit_q  <= bit_d;
        end
    end

    assign bit_o  = bit_q;
    assign done_o = done_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: MOSI frames to 10-bit RAM commands, RAM read data out on MISO.
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FW = DATA_W + 2;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);

    state_e         state_q,    state_d;
    logic [FW-1:0]  rx_data_q,  rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic           frm_done_q, frm_done_d;
    logic           rd_seen_q,  rd_seen_d;
    logic           piso_load;
    logic           piso_done;

    always_comb begin
        state_d    = state_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cnt_d      = cnt_q;
        frm_done_d = frm_done_q;
        rd_seen_d  = rd_seen_q;
        piso_load  = 1'b0;
        if (SS_n) begin
            state_d    = IDLE;
            cnt_d      = '0;
            frm_done_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = CHK_CMD;
                    cnt_d      = '0;
                    frm_done_d = 1'b0;
                end
                CHK_CMD: begin
                    if (!MOSI)         state_d = WRITE;
                    else if (rd_seen_q) state_d = READ_DATA;
                    else               state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!frm_done_q) begin
                        rx_data_d = {rx_data_q[FW-2:0], MOSI};
                        if (cnt_q == CNT_LAST) begin
                            rx_valid_d = 1'b1;
                            frm_done_d = 1'b1;
                            if (state_q == READ_ADD) rd_seen_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (state_q == READ_DATA) begin
                        // Wait for RAM data, then serialise it once.
                        piso_load = tx_valid;
                        if (piso_done) rd_seen_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cnt_q      <= '0;
            frm_done_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cnt_q      <= cnt_d;
            frm_done_q <= frm_done_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    spi_piso_shifter #(
        .W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .clear_i (SS_n),
        .load_i  (piso_load),
        .data_i  (tx_data),
        .bit_o   (MISO),
        .done_o  (piso_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end that drives the single-port RAM's command interface: deserialises MOSI frames into 10-bit RAM commands (rx_data/rx_valid).
- Serialises the RAM's 8-bit read data (tx_data/tx_valid) back out on MISO.
- Sits between the external SPI master and the RAM; clk is the SPI serial clock. MOSI is sampled and MISO is updated on rising edges only.

Parameters:
- DATA_W, 8, RAM data width. rx_data width is DATA_W+2 (2 command bits plus payload). Bit counter width is $clog2(DATA_W+2).

Ports:
- clk  in  1  serial clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- SS_n  in  1  slave select, active-low; frame boundary.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first; registered.
- rx_data  out  DATA_W+2  assembled command word to RAM; [9:8] = 00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid, sampled only while awaiting read data.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high; clock port is clk, reset port is rst.
- Reset values: MISO=0, rx_data=0, rx_valid=0, state=IDLE, bit counter=0, rd_addr_seen=0. Reset mid-frame discards everything, with no rx_valid.
- State machine states are IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- SS_n=1 in any state: next state IDLE, counter cleared, MISO=0, no rx_valid that cycle, and MOSI is not sampled. rd_addr_seen is unchanged by an abort.
- IDLE -> CHK_CMD when SS_n=0.
- CHK_CMD samples MOSI as the command bit; this bit is not shifted into rx_data.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- Collect phase (WRITE, READ_ADD, READ_DATA):
  - On each of 10 consecutive posedges: rx_data <= {rx_data[8:0], MOSI}.
  - rx_valid is high for exactly the one cycle after the 10th sample, with rx_data stable.
  - Bits beyond 10 are ignored in WRITE and READ_ADD; the state holds until SS_n=1.
- READ_ADD: rd_addr_seen is set on the same edge rx_valid rises. It is set only on a completed 10-bit frame.
- READ_DATA, after rx_valid:
  - Wait state with no timeout; MISO=0 while waiting.
  - The first posedge with tx_valid=1 loads tx_data into an output shift register.
  - MISO presents bit DATA_W-1 from the next cycle, then one bit per cycle, for DATA_W cycles.
  - After the last bit: MISO=0, rd_addr_seen cleared, state holds until SS_n=1.
  - With the RAM's 1-cycle latency, MISO bit7 appears 2 cycles after the rx_valid pulse.
- tx_valid outside the READ_DATA wait state is ignored. tx_valid during shift-out is ignored; no reload.
- Aborting READ_DATA (SS_n=1) during the wait or the shift: rd_addr_seen stays 1, so the next read frame goes to READ_DATA again.
- Command bit vs rx_data[9] mismatch is not checked; rx_data is forwarded as received.
- Latency: rx_valid occurs 1 cycle after the 10th MOSI sample. Minimum frame is 1 (CHK_CMD) + 10 + 1 cycles.

Decomposition:
- Package spi_slave_pkg:
  - state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_BITS=10.
- One natural sub-module: spi_piso_shifter, the DATA_W-bit load/shift-out register with a done flag.
- The FSM, deserialiser and counter stay in the top module.

Test Plan:
- Reset: assert rst mid-frame (after 5 MOSI bits) -> MISO=0, rx_valid=0 immediately, state IDLE. Then release and send a full write frame -> accepted normally.
- Write addr: SS_n=0, MOSI 0 then 00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5. Extra MOSI bits before SS_n=1 -> no second pulse.
- Read addr then data:
  - Frame 1: 1, 10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1.
  - Frame 2: 1, 11_0000_0000 -> rx_data=10'h300; model tx_valid with tx_data=8'hC3 one cycle later -> MISO shows 1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
  - A following read frame goes to READ_ADD.
- Abort: SS_n=1 after 6 bits of a WRITE frame -> no rx_valid. The next full frame 00_0000_0001 -> rx_data=10'h001.
- Abort in READ_DATA wait (SS_n=1 before tx_valid) -> the next read frame enters READ_DATA (rd_addr_seen still 1).
- Spurious tx_valid=1 with tx_data=8'hFF in IDLE/WRITE -> MISO stays 0.
